mul_div_unit: RTL

//  Multi-cycle MIPS multiply/divide unit owning the HI/LO registers. Executes MULT/MULTU/DIV/DIVU

---
 rtl/mul_div_unit_pkg.sv | 28 ++
 rtl/mul_div_unit_if.sv | 29 ++
 rtl/mul_div_unit_step.sv | 47 ++++
 rtl/mul_div_unit.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared multiply/divide definitions: op encodings (also used by decode),
// FSM states and step datapath modes.
package md_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [2:0] {
    MD_NOP   = 3'b000,
    MD_MULT  = 3'b001,
    MD_MULTU = 3'b010,
    MD_DIV   = 3'b011,
    MD_DIVU  = 3'b100,
    MD_MTHI  = 3'b101,
    MD_MTLO  = 3'b110
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } md_state_t;

  typedef enum logic {
    MD_MODE_MUL = 1'b0,
    MD_MODE_DIV = 1'b1
  } md_mode_t;

endpackage

// File: rtl/mul_div_unit_if.sv
// EX-stage request/result bundle between pipeline control (master) and the
// multiply/divide unit (slave).
interface mul_div_unit_if
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) ();

  logic [2:0]       ex_md_op;
  logic             ex_md_start;
  logic             ex_md_cancel;
  logic [WIDTH-1:0] ex_a;
  logic [WIDTH-1:0] ex_b;
  logic             ex_md_busy;
  logic             ex_md_done;
  logic [WIDTH-1:0] ex_hi;
  logic [WIDTH-1:0] ex_lo;

  modport master (
    output ex_md_op, ex_md_start, ex_md_cancel, ex_a, ex_b,
    input  ex_md_busy, ex_md_done, ex_hi, ex_lo
  );

  modport slave (
    input  ex_md_op, ex_md_start, ex_md_cancel, ex_a, ex_b,
    output ex_md_busy, ex_md_done, ex_hi, ex_lo
  );

endinterface

// File: rtl/mul_div_unit_step.sv
// One radix-2 iteration on unsigned magnitudes: shift-add multiply or
// restoring shift-subtract divide over a {upper, lower} accumulator.
module md_step
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  input  md_mode_t           mode,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               q_bit
);

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH-1:0] diff_s;

  // Single iteration; divide leaves the LSB clear for the caller to insert q_bit
  always_comb begin
    acc_next = acc;
    q_bit    = 1'b0;
    sum_s    = {1'b0, acc[2*WIDTH-1:WIDTH]} +
               (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    rem_sh_s = acc[2*WIDTH-1:WIDTH-1];
    // remainder stays below the divisor, so a WIDTH-bit difference never wraps
    diff_s   = rem_sh_s[WIDTH-1:0] - opnd;
    case (mode)
      MD_MODE_MUL: begin
        acc_next = {sum_s, acc[WIDTH-1:1]};
      end
      MD_MODE_DIV: begin
        if (rem_sh_s >= {1'b0, opnd}) begin
          q_bit    = 1'b1;
          acc_next = {diff_s, acc[WIDTH-2:0], 1'b0};
        end else begin
          q_bit    = 1'b0;
          acc_next = {rem_sh_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
      end
      default: begin
        acc_next = acc;
      end
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO: WIDTH magnitude steps,
// then one sign-fix/writeback cycle. MTHI/MTLO write directly when idle.
module mul_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst,
  mul_div_unit_if.slave md
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  md_state_t          state_r, state_s;
  logic [CNT_W-1:0]   count_r;
  logic [2*WIDTH-1:0] acc_r, acc_step_s, init_acc_s, prod_s;
  logic [WIDTH-1:0]   opnd_r, init_opnd_s, a_mag_s, b_mag_s;
  logic [WIDTH-1:0]   hi_r, lo_r, fix_hi_s, fix_lo_s, quo_s, rem_s;
  md_mode_t           mode_r, mode_s;
  logic               neg_lo_r, neg_hi_r, init_neg_hi_s;
  logic               busy_r, done_r, q_bit_s;
  logic               start_calc_s, wr_hi_s, wr_lo_s, fix_wr_s;
  logic               signed_s, a_neg_s, b_neg_s;

  md_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_r),
    .opnd     (opnd_r),
    .mode     (mode_r),
    .acc_next (acc_step_s),
    .q_bit    (q_bit_s)
  );

  // Next-state and control strobes
  always_comb begin
    state_s      = state_r;
    start_calc_s = 1'b0;
    wr_hi_s      = 1'b0;
    wr_lo_s      = 1'b0;
    fix_wr_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (md.ex_md_start) begin
          case (md.ex_md_op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              state_s      = CALC;
              start_calc_s = 1'b1;
            end
            MD_MTHI: wr_hi_s = 1'b1;
            MD_MTLO: wr_lo_s = 1'b1;
            default: state_s = IDLE;
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (md.ex_md_cancel) begin
          state_s = IDLE;
        end else if (count_r == LAST_CNT) begin
          state_s = FIX;
        end else begin
          state_s = CALC;
        end
      end
      FIX: begin
        // a flush in the writeback cycle still suppresses the result
        state_s  = IDLE;
        fix_wr_s = ~md.ex_md_cancel;
      end
      default: state_s = IDLE;
    endcase
  end

  // Operand magnitudes and signs captured at start
  always_comb begin
    signed_s = (md.ex_md_op == MD_MULT) || (md.ex_md_op == MD_DIV);
    a_neg_s  = signed_s & md.ex_a[WIDTH-1];
    b_neg_s  = signed_s & md.ex_b[WIDTH-1];
    a_mag_s  = a_neg_s ? -md.ex_a : md.ex_a;
    b_mag_s  = b_neg_s ? -md.ex_b : md.ex_b;
    if ((md.ex_md_op == MD_DIV) || (md.ex_md_op == MD_DIVU)) begin
      mode_s        = MD_MODE_DIV;
      init_opnd_s   = b_mag_s;
      init_acc_s    = {{WIDTH{1'b0}}, a_mag_s};
      init_neg_hi_s = a_neg_s;
    end else begin
      mode_s        = MD_MODE_MUL;
      init_opnd_s   = a_mag_s;
      init_acc_s    = {{WIDTH{1'b0}}, b_mag_s};
      init_neg_hi_s = a_neg_s ^ b_neg_s;
    end
  end

  // Sign correction of the finished magnitude result
  always_comb begin
    prod_s = neg_lo_r ? -acc_r : acc_r;
    quo_s  = neg_lo_r ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
    rem_s  = neg_hi_r ? -acc_r[2*WIDTH-1:WIDTH] : acc_r[2*WIDTH-1:WIDTH];
    if (mode_r == MD_MODE_DIV) begin
      fix_hi_s = rem_s;
      fix_lo_s = quo_s;
    end else begin
      fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
      fix_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // FSM state and handshake flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
      done_r  <= fix_wr_s;
    end
  end

  // Iteration counter and working registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r  <= {CNT_W{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      opnd_r   <= {WIDTH{1'b0}};
      mode_r   <= MD_MODE_MUL;
      neg_lo_r <= 1'b0;
      neg_hi_r <= 1'b0;
    end else if (start_calc_s) begin
      count_r  <= {CNT_W{1'b0}};
      acc_r    <= init_acc_s;
      opnd_r   <= init_opnd_s;
      mode_r   <= mode_s;
      neg_lo_r <= a_neg_s ^ b_neg_s;
      neg_hi_r <= init_neg_hi_s;
    end else if (state_r == CALC) begin
      acc_r   <= acc_step_s | {{(2*WIDTH-1){1'b0}}, q_bit_s};
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // HI/LO architectural registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_r <= {WIDTH{1'b0}};
      lo_r <= {WIDTH{1'b0}};
    end else if (fix_wr_s) begin
      hi_r <= fix_hi_s;
      lo_r <= fix_lo_s;
    end else begin
      if (wr_hi_s) hi_r <= md.ex_a;
      if (wr_lo_s) lo_r <= md.ex_a;
    end
  end

  assign md.ex_md_busy = busy_r;
  assign md.ex_md_done = done_r;
  assign md.ex_hi      = hi_r;
  assign md.ex_lo      = lo_r;

endmodule
